tlb_op_ctrl: RTL and testbench

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

---
 rtl/tlb_op_ctrl.sv | 140 ++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBR/TLBWI/TLBWR/TLBP against the MMU port. Done pulses 2 cycles after acceptance.
// op_ready is high only while idle, and the block keeps no queue; the Random register runs in the background.
package tlb_op_ctrl_pkg;

  typedef struct packed {
    logic [31:0] entry_hi;
    logic [31:0] entry_lo0;
    logic [31:0] entry_lo1;
    logic [31:0] page_mask;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    OP_TLBR  = 2'd0,
    OP_TLBWI = 2'd1,
    OP_TLBWR = 2'd2,
    OP_TLBP  = 2'd3
  } op_type_e;

endpackage

module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int N_TLB_ENTRIES = 32,
  localparam int IW = $clog2(N_TLB_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic [1:0]    op_type,
  output logic          op_ready,
  input  logic [IW-1:0] cp0_index,
  input  logic [IW-1:0] cp0_wired,
  input  logic          cp0_wired_we,
  input  tlb_entry_t    cp0_entry,
  input  logic [31:0]   cp0_entry_hi,
  output logic [IW-1:0] tlbrw_index,
  output logic          tlbrw_we,
  output tlb_entry_t    tlbrw_wrdata,
  input  tlb_entry_t    tlbrw_rddata,
  output logic [31:0]   tlbp_entry_hi,
  input  logic [31:0]   tlbp_index,
  output logic          done,
  output tlb_entry_t    rd_entry,
  output logic [31:0]   probe_index,
  output logic [IW-1:0] random
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [IW-1:0] RAND_MAX = IW'(N_TLB_ENTRIES - 1);

  state_e        state_q, state_d;
  op_type_e      op_q, op_d;
  logic [IW-1:0] idx_q, idx_d;
  tlb_entry_t    entry_q, entry_d;
  logic [31:0]   ehi_q, ehi_d;
  tlb_entry_t    rd_entry_q, rd_entry_d;
  logic [31:0]   probe_q, probe_d;
  logic [IW-1:0] random_q, random_d;
  logic [IW:0]   wired_lim;

  // Random reloads when the next decrement would land on or below Wired.
  assign wired_lim = {1'b0, cp0_wired} + {{IW{1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    entry_d    = entry_q;
    ehi_d      = ehi_q;
    rd_entry_d = rd_entry_q;
    probe_d    = probe_q;
    op_ready   = 1'b0;
    done       = 1'b0;
    tlbrw_we   = 1'b0;

    case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          state_d = S_EXEC;
          op_d    = op_type_e'(op_type);
          idx_d   = (op_type_e'(op_type) == OP_TLBWR) ? random_q : cp0_index;
          entry_d = cp0_entry;
          ehi_d   = cp0_entry_hi;
        end
      end
      S_EXEC: begin
        tlbrw_we = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);
        if (op_q == OP_TLBR) rd_entry_d = tlbrw_rddata;
        if (op_q == OP_TLBP) probe_d = tlbp_index;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    random_d = random_q - {{(IW-1){1'b0}}, 1'b1};
    if (cp0_wired_we || ({1'b0, random_q} <= wired_lim)) random_d = RAND_MAX;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_TLBR;
      idx_q      <= '0;
      entry_q    <= '0;
      ehi_q      <= '0;
      rd_entry_q <= '0;
      probe_q    <= '0;
      random_q   <= RAND_MAX;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      entry_q    <= entry_d;
      ehi_q      <= ehi_d;
      rd_entry_q <= rd_entry_d;
      probe_q    <= probe_d;
      random_q   <= random_d;
    end
  end

  // The latched operands drive the MMU directly, so they hold after EXEC.
  assign tlbrw_index   = idx_q;
  assign tlbrw_wrdata  = entry_q;
  assign tlbp_entry_hi = ehi_q;
  assign rd_entry      = rd_entry_q;
  assign probe_index   = probe_q;
  assign random        = random_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: MMU stub, write/done scoreboard, per-feature tasks.
module tb_tlb_op_ctrl;
  import tlb_op_ctrl_pkg::*;

  localparam int N  = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_valid = 1'b0;
  logic [1:0]    op_type = 2'd0;
  logic          op_ready;
  logic [IW-1:0] cp0_index = '0;
  logic [IW-1:0] cp0_wired = '0;
  logic          cp0_wired_we = 1'b0;
  tlb_entry_t    cp0_entry = '0;
  logic [31:0]   cp0_entry_hi = '0;
  logic [IW-1:0] tlbrw_index;
  logic          tlbrw_we;
  tlb_entry_t    tlbrw_wrdata;
  tlb_entry_t    tlbrw_rddata;
  logic [31:0]   tlbp_entry_hi;
  logic [31:0]   tlbp_index = '0;
  logic          done;
  tlb_entry_t    rd_entry;
  logic [31:0]   probe_index;
  logic [IW-1:0] random;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [1:0] kind; tlb_entry_t rd; logic [31:0] probe; } done_exp_t;
  typedef struct { logic [IW-1:0] idx; tlb_entry_t dat; } wr_exp_t;
  done_exp_t done_q[$];
  wr_exp_t   wr_q[$];
  tlb_entry_t mmu_mem[N];
  tlb_entry_t exp_mem[N];

  tlb_op_ctrl #(.N_TLB_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready),
    .cp0_index(cp0_index), .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we),
    .cp0_entry(cp0_entry), .cp0_entry_hi(cp0_entry_hi), .tlbrw_index(tlbrw_index),
    .tlbrw_we(tlbrw_we), .tlbrw_wrdata(tlbrw_wrdata), .tlbrw_rddata(tlbrw_rddata),
    .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index), .done(done),
    .rd_entry(rd_entry), .probe_index(probe_index), .random(random)
  );

  always #5 clk = ~clk;

  function automatic tlb_entry_t mk_entry(input int i);
    tlb_entry_t e;
    e.entry_hi  = 32'h1000_0000 + i;
    e.entry_lo0 = 32'h2000_0000 + i * 3;
    e.entry_lo1 = 32'h3000_0000 ^ i;
    e.page_mask = i * 32'h100;
    return e;
  endfunction

  // MMU stub: synchronous write, combinational read.
  always @(posedge clk) if (tlbrw_we) mmu_mem[tlbrw_index] = tlbrw_wrdata;
  assign tlbrw_rddata = mmu_mem[tlbrw_index];

  always @(negedge clk) begin
    wr_exp_t w;
    done_exp_t d;
    if (rst) begin
      if (tlbrw_we) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL sb_write_unexpected idx=%0d data=%h expected no write", tlbrw_index, tlbrw_wrdata);
        end else begin
          w = wr_q.pop_front();
          if (tlbrw_index !== w.idx || tlbrw_wrdata !== w.dat) begin
            errors++;
            $display("FAIL sb_write got idx=%0d data=%h want idx=%0d data=%h", tlbrw_index, tlbrw_wrdata, w.idx, w.dat);
          end
        end
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL sb_done_unexpected got done=1 expected no completion");
        end else begin
          d = done_q.pop_front();
          if (d.kind == 2'd0 && rd_entry !== d.rd) begin
            errors++;
            $display("FAIL sb_rd_entry got=%h want=%h", rd_entry, d.rd);
          end
          if (d.kind == 2'd3 && probe_index !== d.probe) begin
            errors++;
            $display("FAIL sb_probe_index got=%h want=%h", probe_index, d.probe);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] t, input logic [IW-1:0] idx, input tlb_entry_t e,
                          input logic [31:0] pres);
    done_exp_t d;
    wr_exp_t w;
    if (t == 2'd1 || t == 2'd2) begin
      w.idx = idx;
      w.dat = e;
      wr_q.push_back(w);
    end
    d.kind  = t;
    d.rd    = exp_mem[idx];
    d.probe = pres;
    done_q.push_back(d);
  endtask

  // Called #1 after an edge with the FSM idle; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] t, input logic [IW-1:0] idx, input tlb_entry_t e,
                       input logic [31:0] ehi, input logic [31:0] pres);
    push_exp(t, idx, e, pres);
    op_valid     = 1'b1;
    op_type      = t;
    cp0_index    = (t == 2'd2) ? idx + 5'd1 : idx;
    cp0_entry    = e;
    cp0_entry_hi = ehi;
    tlbp_index   = pres;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_random(input logic [IW-1:0] v);
    int n = 0;
    while (random !== v && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (random !== v) begin
      errors++;
      $display("FAIL wait_random got=%0d want=%0d", random, v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    checks++;
    if (op_ready !== 1'b1 || done !== 1'b0 || tlbrw_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b done=%b we=%b want 1 0 0", op_ready, done, tlbrw_we);
    end
    checks++;
    if (tlbrw_index !== '0 || tlbrw_wrdata !== '0 || tlbp_entry_hi !== '0) begin
      errors++;
      $display("FAIL reset_mmu got idx=%0d wr=%h ehi=%h want zeros", tlbrw_index, tlbrw_wrdata, tlbp_entry_hi);
    end
    checks++;
    if (rd_entry !== '0 || probe_index !== '0 || random !== 5'd31) begin
      errors++;
      $display("FAIL reset_results got rd=%h probe=%h random=%0d want 0 0 31", rd_entry, probe_index, random);
    end
  endtask

  task automatic test_random_seq();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (random !== 5'(31 - i) || op_ready !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL random_seq[%0d] got random=%0d ready=%b done=%b want %0d 1 0", i, random, op_ready, done, 31 - i);
      end
      if (i < 5) step();
    end
  endtask

  task automatic test_tlbwi();
    tlb_entry_t e = mk_entry(100);
    issue(2'd1, 5'd7, e, 32'h0, 32'h0);
    checks++;
    if (tlbrw_we !== 1'b1 || tlbrw_index !== 5'd7 || op_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL tlbwi_exec got we=%b idx=%0d ready=%b done=%b want 1 7 0 0", tlbrw_we, tlbrw_index, op_ready, done);
    end
    step();
    checks++;
    if (done !== 1'b1 || op_ready !== 1'b0 || tlbrw_we !== 1'b0) begin
      errors++;
      $display("FAIL tlbwi_done got done=%b ready=%b we=%b want 1 0 0", done, op_ready, tlbrw_we);
    end
    step();
    checks++;
    if (op_ready !== 1'b1 || done !== 1'b0 || tlbrw_index !== 5'd7 || tlbrw_wrdata !== e) begin
      errors++;
      $display("FAIL tlbwi_idle got ready=%b done=%b idx=%0d want 1 0 7 (held)", op_ready, done, tlbrw_index);
    end
    exp_mem[7] = e;
  endtask

  task automatic test_tlbr();
    issue(2'd0, 5'd3, mk_entry(999), 32'h0, 32'h0);
    step();
    checks++;
    if (done !== 1'b1 || rd_entry !== mk_entry(3)) begin
      errors++;
      $display("FAIL tlbr_result got done=%b rd=%h want 1 %h", done, rd_entry, mk_entry(3));
    end
    step();
  endtask

  task automatic test_tlbp();
    issue(2'd3, 5'd0, mk_entry(0), 32'hABCD_0000, 32'h8000_0000);
    checks++;
    if (tlbp_entry_hi !== 32'hABCD_0000 || tlbrw_we !== 1'b0) begin
      errors++;
      $display("FAIL tlbp_key got ehi=%h we=%b want abcd0000 0", tlbp_entry_hi, tlbrw_we);
    end
    cp0_entry_hi = 32'h0;
    op_type = 2'd1;
    step();
    checks++;
    if (probe_index !== 32'h8000_0000) begin
      errors++;
      $display("FAIL tlbp_miss got=%h want 80000000", probe_index);
    end
    step();
    checks++;
    if (tlbp_entry_hi !== 32'hABCD_0000) begin
      errors++;
      $display("FAIL tlbp_key_hold got=%h want abcd0000", tlbp_entry_hi);
    end
    issue(2'd3, 5'd0, mk_entry(0), 32'h1234_5000, 32'd5);
    step();
    checks++;
    if (probe_index !== 32'd5 || rd_entry !== mk_entry(3)) begin
      errors++;
      $display("FAIL tlbp_hit got probe=%h rd=%h want 5 %h", probe_index, rd_entry, mk_entry(3));
    end
    step();
  endtask

  task automatic test_wired();
    cp0_wired = 5'd0;
    wait_random(5'd5);
    cp0_wired = 5'd4;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (random !== 5'(31 - i)) begin
        errors++;
        $display("FAIL wired_wrap[%0d] got=%0d want=%0d", i, random, 31 - i);
      end
    end
    cp0_wired_we = 1'b1;
    step();
    cp0_wired_we = 1'b0;
    checks++;
    if (random !== 5'd31) begin
      errors++;
      $display("FAIL wired_we got=%0d want 31", random);
    end
    cp0_wired = 5'd31;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (random !== 5'd31) begin
        errors++;
        $display("FAIL wired_max[%0d] got=%0d want 31", i, random);
      end
    end
    cp0_wired = 5'd0;
  endtask

  task automatic test_tlbwr();
    tlb_entry_t e = mk_entry(200);
    wait_random(5'd12);
    issue(2'd2, 5'd12, e, 32'h0, 32'h0);
    checks++;
    if (tlbrw_we !== 1'b1 || tlbrw_index !== 5'd12) begin
      errors++;
      $display("FAIL tlbwr_exec got we=%b idx=%0d want 1 12", tlbrw_we, tlbrw_index);
    end
    cp0_wired_we = 1'b1;
    op_valid = 1'b1;
    op_type = 2'd0;
    step();
    cp0_wired_we = 1'b0;
    op_valid = 1'b0;
    checks++;
    if (random !== 5'd31 || done !== 1'b1 || tlbrw_index !== 5'd12) begin
      errors++;
      $display("FAIL tlbwr_done got random=%0d done=%b idx=%0d want 31 1 12", random, done, tlbrw_index);
    end
    step();
    checks++;
    if (op_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL tlbwr_noqueue got ready=%b done=%b want 1 0", op_ready, done);
    end
    exp_mem[12] = e;
  endtask

  task automatic test_reset_mid_op();
    issue(2'd1, 5'd20, mk_entry(300), 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    checks++;
    if (tlbrw_we !== 1'b0 || done !== 1'b0 || tlbrw_index !== '0 || random !== 5'd31) begin
      errors++;
      $display("FAIL abort_reset got we=%b done=%b idx=%0d random=%0d want 0 0 0 31", tlbrw_we, done, tlbrw_index, random);
    end
    step();
    wr_q.delete();
    done_q.delete();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || tlbrw_we !== 1'b0 || rd_entry !== '0 || probe_index !== '0) begin
        errors++;
        $display("FAIL abort_quiet[%0d] got done=%b we=%b rd=%h probe=%h want 0 0 0 0", i, done, tlbrw_we, rd_entry, probe_index);
      end
    end
    checks++;
    if (mmu_mem[20] !== mk_entry(20)) begin
      errors++;
      $display("FAIL abort_nowrite got=%h want=%h", mmu_mem[20], mk_entry(20));
    end
    issue(2'd0, 5'd7, mk_entry(0), 32'h0, 32'h0);
    step();
    checks++;
    if (done !== 1'b1 || rd_entry !== exp_mem[7]) begin
      errors++;
      $display("FAIL post_reset_tlbr got done=%b rd=%h want 1 %h", done, rd_entry, exp_mem[7]);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  kinds[3] = '{2'd1, 2'd0, 2'd3};
    logic [31:0] pres = 32'h0000_0011;
    tlb_entry_t  e = mk_entry(400);
    int k = 0;
    int cyc = 0;
    op_valid = 1'b1;
    while (k < 3 && cyc < 20) begin
      if (op_ready === 1'b1) begin
        checks++;
        if (cyc !== 3 * k) begin
          errors++;
          $display("FAIL b2b_accept[%0d] got cycle=%0d want %0d", k, cyc, 3 * k);
        end
        op_type      = kinds[k];
        cp0_index    = 5'd9;
        cp0_entry    = e;
        cp0_entry_hi = 32'h5555_0000;
        tlbp_index   = pres;
        push_exp(kinds[k], 5'd9, e, pres);
        if (k == 0) exp_mem[9] = e;
        k++;
      end
      step();
      cyc++;
    end
    op_valid = 1'b0;
    step();
    step();
    step();
    checks++;
    if (k !== 3 || done_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got accepted=%0d pending_done=%0d pending_wr=%0d want 3 0 0", k, done_q.size(), wr_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      mmu_mem[i] = mk_entry(i);
      exp_mem[i] = mk_entry(i);
    end
    #2;
    test_reset();
    test_random_seq();
    test_tlbwi();
    test_tlbr();
    test_tlbp();
    test_wired();
    test_tlbwr();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
